dual_port_ram_be: RTL and testbench

Parametrised simple dual-port RAM: one write port and one registered read port on a single clock. It generalises the team's 8x16 dual-port RAM with derived address width, per-byte write enables, address-range checking, and a sequential power-up clear engine. It also offers optional write-to-read forwarding. It sits beside the existing RAM as the buffer primitive for packet and FIFO blocks.

---
 rtl/dual_port_ram_pkg.sv | 23 ++
 rtl/dual_port_ram_clear_fsm.sv | 71 +++++++
 rtl/dual_port_ram_be.sv | 116 +++++++++++
 tb/tb_dual_port_ram_be.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// ============================================================================
// dual_port_ram_pkg : shared state encoding and byte-merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package dual_port_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // One byte lane of a masked write: new data where enabled, old data elsewhere.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be_b);
    return be_b ? new_b : old_b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dual_port_ram_clear_fsm.sv
// ============================================================================
// dual_port_ram_clear_fsm : INIT/READY control and sequential zero-fill pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module dual_port_ram_clear_fsm
  import dual_port_ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  output state_e            state_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              init_busy_o
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clock_i) begin
    if (resetn_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_q == C_LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign state_o     = state_q;
  assign clr_we_o    = (state_q == ST_INIT);
  assign clr_addr_o  = ptr_q;
  assign init_busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/dual_port_ram_be.sv
// ============================================================================
// dual_port_ram_be : simple dual-port RAM, byte enables, range check, zero-fill
// Optional macro DUAL_PORT_RAM_BYPASS_EN selects write-first collision reads.
// Rev 1.0
// ============================================================================
`default_nettype none

module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = WIDTH / 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_enb,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              re_enb,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              addr_err,
  output logic              init_busy
);

  localparam logic [ADDR_W:0] C_DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  state_e            state;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              wr_in_range, rd_in_range, wr_acc;
  logic [WIDTH-1:0]  wr_old, wr_merged, rd_word, rd_fwd;

  dual_port_ram_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock_i     (clock),
    .resetn_i    (resetn),
    .state_o     (state),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .init_busy_o (init_busy)
  );

  assign ready       = (state == ST_READY);
  assign wr_in_range = ({1'b0, wr_addr} < C_DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < C_DEPTH_X);
  assign wr_acc      = ready & wr_enb & wr_in_range;
  assign wr_old      = mem_q[wr_addr];
  assign rd_word     = mem_q[rd_addr];

  for (genvar k = 0; k < BE_W; k++) begin : g_byte
    assign wr_merged[8*k +: 8] = byte_merge(wr_old[8*k +: 8], data_in[8*k +: 8], wr_be[k]);
  end

`ifdef DUAL_PORT_RAM_BYPASS_EN
  // Same-address collision returns the post-write word (write-first).
  assign rd_fwd = (wr_acc && (wr_addr == rd_addr)) ? wr_merged : rd_word;
`else
  assign rd_fwd = rd_word;
`endif

  // The array has no reset; the clear engine zero-fills it after reset drops.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      if (clr_we) begin
        mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
        mem_q[wr_addr] <= wr_merged;
      end
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    if (ready) begin
      if (re_enb) begin
        rd_valid_d = 1'b1;
        data_out_d = rd_in_range ? rd_fwd : '0;
      end
      addr_err_d = (wr_enb & ~wr_in_range) | (re_enb & ~rd_in_range);
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_be.sv
// ============================================================================
// tb_dual_port_ram_be : directed table-driven bench, WIDTH=16 DEPTH=12
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dual_port_ram_be;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;

`ifdef DUAL_PORT_RAM_BYPASS_EN
  localparam logic [15:0] C_COLL_EXP = 16'h5A5A;
`else
  localparam logic [15:0] C_COLL_EXP = 16'h0000;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic              wr_enb;
  logic [1:0]        wr_be;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  data_in;
  logic              re_enb;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  data_out;
  logic              rd_valid;
  logic              addr_err;
  logic              init_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  dual_port_ram_be #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .wr_enb    (wr_enb),
    .wr_be     (wr_be),
    .wr_addr   (wr_addr),
    .data_in   (data_in),
    .re_enb    (re_enb),
    .rd_addr   (rd_addr),
    .data_out  (data_out),
    .rd_valid  (rd_valid),
    .addr_err  (addr_err),
    .init_busy (init_busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        re;
    logic [3:0]  raddr;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic idle();
    wr_enb = 1'b0; wr_be = 2'b00; wr_addr = '0; data_in = '0;
    re_enb = 1'b0; rd_addr = '0;
  endtask

  // Counts cycles with init_busy high starting now; also flags any rd_valid/addr_err seen.
  task automatic count_busy(output int n, output bit done, output bit bad);
    n = 0; done = 1'b0; bad = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (rd_valid || addr_err) bad = 1'b1;
      if (init_busy) n++;
      else done = 1'b1;
      if (!done) step();
    end
  endtask

  int n_busy;
  bit done, bad;

  initial begin
    vecs[0]  = '{1'b1, 2'b11, 4'd5,  16'hAABB, 1'b0, 4'd0,  1'b0, 16'h0000,   1'b0};
    vecs[1]  = '{1'b1, 2'b01, 4'd5,  16'h1122, 1'b0, 4'd0,  1'b0, 16'h0000,   1'b0};
    vecs[2]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b1, 16'hAA22,   1'b0};
    vecs[3]  = '{1'b1, 2'b11, 4'd3,  16'h5A5A, 1'b1, 4'd3,  1'b1, C_COLL_EXP, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 16'h5A5A,   1'b0};
    vecs[5]  = '{1'b1, 2'b11, 4'd13, 16'h1234, 1'b0, 4'd0,  1'b0, 16'h5A5A,   1'b1};
    vecs[6]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 4'd1,  1'b1, 16'h0000,   1'b0};
    vecs[7]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 4'd14, 1'b1, 16'h0000,   1'b1};
    vecs[8]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 16'h0000,   1'b0};
    vecs[9]  = '{1'b1, 2'b10, 4'd7,  16'hCCDD, 1'b1, 4'd5,  1'b1, 16'hAA22,   1'b0};
    vecs[10] = '{1'b1, 2'b00, 4'd7,  16'hEEFF, 1'b1, 4'd7,  1'b1, 16'hCC00,   1'b0};
    vecs[11] = '{1'b1, 2'b11, 4'd13, 16'h1111, 1'b1, 4'd7,  1'b1, 16'hCC00,   1'b1};
    vecs[12] = '{1'b1, 2'b11, 4'd0,  16'h9999, 1'b1, 4'd1,  1'b1, 16'h0000,   1'b0};
    vecs[13] = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 4'd0,  1'b1, 16'h9999,   1'b0};

    idle();
    resetn = 1'b1;
    repeat (3) step();
    chk("rst_busy",  32'(init_busy), 32'd1);
    chk("rst_valid", 32'(rd_valid),  32'd0);
    chk("rst_data",  32'(data_out),  32'd0);
    chk("rst_err",   32'(addr_err),  32'd0);

    // Requests during the clear must be ignored.
    resetn = 1'b0;
    wr_enb = 1'b1; wr_be = 2'b11; wr_addr = 4'd2; data_in = 16'hFFFF;
    re_enb = 1'b1; rd_addr = 4'd2;
    count_busy(n_busy, done, bad);
    idle();
    chk("clear_done",     32'(done),   32'd1);
    chk("clear_cycles",   32'(n_busy), 32'd12);
    chk("clear_no_valid", 32'(bad),    32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      re_enb = 1'b1; rd_addr = 4'(i);
      step();
      chk($sformatf("clr_rd%0d_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("clr_rd%0d_data", i),  32'(data_out), 32'd0);
    end
    idle();

    for (int v = 0; v < 14; v++) begin
      wr_enb = vecs[v].we; wr_be = vecs[v].be; wr_addr = vecs[v].waddr; data_in = vecs[v].wdata;
      re_enb = vecs[v].re; rd_addr = vecs[v].raddr;
      step();
      chk($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_data", v),  32'(data_out), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_err", v),   32'(addr_err), 32'(vecs[v].exp_err));
    end
    idle();

    // Back-to-back: write i with i*3 while reading i-1.
    for (int i = 0; i <= DEPTH; i++) begin
      wr_enb = (i < DEPTH); wr_be = 2'b11; wr_addr = 4'(i % DEPTH); data_in = 16'(i * 3);
      re_enb = (i > 0); rd_addr = 4'((i > 0) ? i - 1 : 0);
      step();
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i), 32'(rd_valid), 32'd1);
        chk($sformatf("b2b%0d_data", i),  32'(data_out), 32'((i - 1) * 3));
      end
    end
    idle();

    // Reset discards a read issued on the same edge.
    re_enb = 1'b1; rd_addr = 4'd4; resetn = 1'b1;
    step();
    idle();
    chk("rst_read_valid", 32'(rd_valid), 32'd0);
    chk("rst_read_data",  32'(data_out), 32'd0);

    // Reset again once the clear pointer reaches 6.
    resetn = 1'b0;
    repeat (6) step();
    chk("midclr_busy_pre", 32'(init_busy), 32'd1);
    resetn = 1'b1;
    step();
    chk("midclr_busy_rst", 32'(init_busy), 32'd1);
    resetn = 1'b0;
    count_busy(n_busy, done, bad);
    chk("midclr_done",   32'(done),   32'd1);
    chk("midclr_cycles", 32'(n_busy), 32'd12);

    for (int i = 0; i < DEPTH; i++) begin
      re_enb = 1'b1; rd_addr = 4'(i);
      step();
      chk($sformatf("midclr_rd%0d", i), {15'd0, rd_valid, data_out}, {15'd0, 1'b1, 16'h0000});
    end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
